// File: rtl/io_conditioner.sv
// io_conditioner
//   Front-end conditioning for a board's slow asynchronous I/O:
//   - synchronises N_IN plain levels (UART rx/cts style, idle-high),
//   - synchronises and debounces an active-low push button,
//   - generates a power-on reset count and a registered active-low
//     system reset that a debounced button press can also assert.
//
// Ports
//   clk          in   single clock, every flop lives here
//   reset        in   asynchronous, active-high
//   ext_in       in   [N_IN]  asynchronous external levels
//   ext_btn_n    in   asynchronous button, pressed = 0
//   sync_in      out  [N_IN]  ext_in after SYNC_STAGES flops
//   btn_pressed  out  debounced button state, 1 = pressed
//   btn_pulse    out  one-cycle strobe on each accepted press
//   sys_resetn   out  registered active-low downstream reset
//   por_done     out  power-on count has expired (sticky until reset)
//
// Handshake: none. All inputs are free-running levels and all outputs
// are registered levels/strobes; there is no valid/ready protocol here.

module io_conditioner #(
  parameter int              N_IN            = 2,
  parameter int              SYNC_STAGES     = 2,
  parameter logic [N_IN-1:0] IN_RESET_VAL    = '1,
  parameter int              DEBOUNCE_CYCLES = 16,
  parameter int              POR_CYCLES      = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] ext_in,
  input  logic            ext_btn_n,
  output logic [N_IN-1:0] sync_in,
  output logic            btn_pressed,
  output logic            btn_pulse,
  output logic            sys_resetn,
  output logic            por_done
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(POR_CYCLES + 1);

  // Counter value on the cycle before it would reach DEBOUNCE_CYCLES.
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] POR_LOAD = PW'(POR_CYCLES);
  localparam logic [PW-1:0] POR_ONE  = PW'(1);

  // ---------------------------------------------------------------
  // Level synchronisers
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N_IN-1:0] in_q;
  logic [SYNC_STAGES-1:0]           btn_q;
  logic                             btn_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q  <= {SYNC_STAGES{IN_RESET_VAL}};
      btn_q <= '1;  // button chain rests at "released"
    end else begin
      in_q  <= {in_q[SYNC_STAGES-2:0], ext_in};
      btn_q <= {btn_q[SYNC_STAGES-2:0], ext_btn_n};
    end
  end

  assign sync_in = in_q[SYNC_STAGES-1];
  assign btn_raw = ~btn_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------
  // Debouncer: a new level is accepted only after it has differed
  // from the stable level on DEBOUNCE_CYCLES consecutive edges.
  // ---------------------------------------------------------------
  logic [DW-1:0] db_cnt;
  logic          db_match;
  logic          db_accept;

  always_comb begin
    db_match  = (btn_raw == btn_pressed);
    db_accept = !db_match && (db_cnt == DB_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt      <= '0;
      btn_pressed <= 1'b0;
      btn_pulse   <= 1'b0;
    end else begin
      if (db_match || db_accept) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      if (db_accept) begin
        btn_pressed <= btn_raw;
      end
      // Strobe coincides with the first cycle btn_pressed reads 1.
      btn_pulse <= db_accept & btn_raw;
    end
  end

  // ---------------------------------------------------------------
  // Power-on reset counter and system reset
  // ---------------------------------------------------------------
  logic [PW-1:0] por_cnt;
  logic          por_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      por_cnt    <= POR_LOAD;
      por_done   <= 1'b0;
      por_hold   <= 1'b0;
      sys_resetn <= 1'b0;
    end else begin
      if (por_cnt != '0) begin
        por_cnt <= por_cnt - 1'b1;
      end
      // Set on the 1->0 step or if already at 0; sticky until reset.
      por_done <= por_done | (por_cnt <= POR_ONE);
      // A button already held while the POR count runs would otherwise
      // let sys_resetn blip high between POR expiry and the debouncer
      // accepting the press. Remember such a press while it is held.
      por_hold <= btn_raw & (por_hold | ~por_done);
      sys_resetn <= por_done & ~btn_pressed & ~(por_hold & btn_raw);
    end
  end

endmodule

// File: tb/tb_io_conditioner.sv
// tb_io_conditioner
//   Directed bench for io_conditioner. Three instances share clock,
//   reset and ext_in:
//     u_a : defaults (SYNC 2, DEBOUNCE 16, POR 3)
//     u_b : SYNC 3, POR 8 (sync latency, press held through POR)
//     u_c : DEBOUNCE 1 (single-cycle acceptance)
//   Time is counted in edges t after the edge at which reset is
//   released (edge 0). Expected values are pushed to a queue before
//   each edge and popped/compared #1 after it.

module tb_io_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ext_in;
  logic       btn_n_a, btn_n_b, btn_n_c;

  logic [1:0] sync_a, sync_b, sync_c;
  logic       pressed_a, pulse_a, resetn_a, por_a;
  logic       pressed_b, pulse_b, resetn_b, por_b;
  logic       pressed_c, pulse_c, resetn_c, por_c;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  io_conditioner u_a (
    .clk(clk), .reset(reset), .ext_in(ext_in), .ext_btn_n(btn_n_a),
    .sync_in(sync_a), .btn_pressed(pressed_a), .btn_pulse(pulse_a),
    .sys_resetn(resetn_a), .por_done(por_a)
  );

  io_conditioner #(.N_IN(2), .SYNC_STAGES(3), .POR_CYCLES(8)) u_b (
    .clk(clk), .reset(reset), .ext_in(ext_in), .ext_btn_n(btn_n_b),
    .sync_in(sync_b), .btn_pressed(pressed_b), .btn_pulse(pulse_b),
    .sys_resetn(resetn_b), .por_done(por_b)
  );

  io_conditioner #(.DEBOUNCE_CYCLES(1)) u_c (
    .clk(clk), .reset(reset), .ext_in(ext_in), .ext_btn_n(btn_n_c),
    .sync_in(sync_c), .btn_pressed(pressed_c), .btn_pulse(pulse_c),
    .sys_resetn(resetn_c), .por_done(por_c)
  );

  // ---------------- scoreboard ----------------
  task automatic push_exp(input string tag, input logic [7:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_obs(input logic [7:0] obs, input int t);
    logic [7:0] e;
    string      tag;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_underflow: observed %0h required an expected entry", obs);
      return;
    end
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, e);
    end
  endtask

  function automatic logic [7:0] b8(input logic b);
    return {7'b0, b};
  endfunction

  function automatic logic [7:0] v8(input logic [1:0] v);
    return {6'b0, v};
  endfunction

  // One edge of the main timeline: push expectations for edge t,
  // clock, then compare in the same order.
  task automatic main_edge(input int t);
    push_exp("a_sync",    v8((t >= 4) ? 2'b01 : 2'b11));
    push_exp("a_por",     b8(t >= 3));
    push_exp("a_pressed", b8(t >= 128 && t < 168));
    push_exp("a_pulse",   b8(t == 128));
    push_exp("a_resetn",  b8(t >= 4 && !(t >= 129 && t < 169)));
    push_exp("b_sync",    v8((t >= 5) ? 2'b01 : 2'b11));
    push_exp("b_por",     b8(t >= 8));
    push_exp("b_pressed", b8(t >= 19 && t < 69));
    push_exp("b_pulse",   b8(t == 19));
    push_exp("b_resetn",  b8(t >= 70));
    push_exp("c_por",     b8(t >= 3));
    push_exp("c_pressed", b8(t == 13));
    push_exp("c_pulse",   b8(t == 13));
    push_exp("c_resetn",  b8(t >= 4 && t != 14));
    @(posedge clk); #1;
    check_obs(v8(sync_a), t);
    check_obs(b8(por_a), t);
    check_obs(b8(pressed_a), t);
    check_obs(b8(pulse_a), t);
    check_obs(b8(resetn_a), t);
    check_obs(v8(sync_b), t);
    check_obs(b8(por_b), t);
    check_obs(b8(pressed_b), t);
    check_obs(b8(pulse_b), t);
    check_obs(b8(resetn_b), t);
    check_obs(b8(por_c), t);
    check_obs(b8(pressed_c), t);
    check_obs(b8(pulse_c), t);
    check_obs(b8(resetn_c), t);
  endtask

  // Timeline after the mid-debounce reset: button on u_a still held.
  task automatic restart_edge(input int t);
    push_exp("r_a_sync",    v8((t >= 2) ? 2'b01 : 2'b11));
    push_exp("r_a_por",     b8(t >= 3));
    push_exp("r_a_pressed", b8(t >= 18));
    push_exp("r_a_pulse",   b8(t == 18));
    push_exp("r_a_resetn",  8'h00);
    @(posedge clk); #1;
    check_obs(v8(sync_a), t);
    check_obs(b8(por_a), t);
    check_obs(b8(pressed_a), t);
    check_obs(b8(pulse_a), t);
    check_obs(b8(resetn_a), t);
  endtask

  task automatic check_reset_values(input string phase);
    push_exp({phase, "_a_sync"},    8'h03);
    push_exp({phase, "_a_pressed"}, 8'h00);
    push_exp({phase, "_a_pulse"},   8'h00);
    push_exp({phase, "_a_resetn"},  8'h00);
    push_exp({phase, "_a_por"},     8'h00);
    push_exp({phase, "_b_sync"},    8'h03);
    push_exp({phase, "_b_por"},     8'h00);
    push_exp({phase, "_c_resetn"},  8'h00);
    check_obs(v8(sync_a), -1);
    check_obs(b8(pressed_a), -1);
    check_obs(b8(pulse_a), -1);
    check_obs(b8(resetn_a), -1);
    check_obs(b8(por_a), -1);
    check_obs(v8(sync_b), -1);
    check_obs(b8(por_b), -1);
    check_obs(b8(resetn_c), -1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset   = 1'b1;
    ext_in  = 2'b11;
    btn_n_a = 1'b1;
    btn_n_b = 1'b0;  // u_b button held from before reset release
    btn_n_c = 1'b1;

    #2;
    check_reset_values("por_reset");

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;  // this edge is t = 0

    for (int t = 1; t <= 202; t++) begin
      main_edge(t);
      case (t)
        2:   ext_in  = 2'b01;
        10:  btn_n_c = 1'b0;
        11:  btn_n_c = 1'b1;
        50:  btn_n_b = 1'b1;
        80:  btn_n_a = 1'b0;  // 15-cycle glitch
        95:  btn_n_a = 1'b1;
        110: btn_n_a = 1'b0;  // 40-cycle press
        150: btn_n_a = 1'b1;
        190: btn_n_a = 1'b0;  // press interrupted by reset
        default: ;
      endcase
    end

    // Debounce count on u_a is 10 here; reset between edges and look
    // before the next edge arrives.
    #2 reset = 1'b1;
    #1;
    check_reset_values("async_reset");

    @(posedge clk);
    #1 reset = 1'b0;  // restart t = 0, button on u_a still held

    for (int t = 1; t <= 20; t++) begin
      restart_edge(t);
    end
    btn_n_a = 1'b1;

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
